// File: rtl/add_sub_if.sv
// add_sub_if: operand/result stream bundle for add_sub_pipe
interface add_sub_if #(
    parameter int WIDTH = 16
);
    logic             in_valid, in_ready, cin, sub;
    logic             out_valid, out_ready, cout, ovf;
    logic [WIDTH-1:0] a, b, s;
    modport master (
        output in_valid, a, b, cin, sub, out_ready,
        input  in_ready, out_valid, s, cout, ovf
    );
    modport slave (
        input  in_valid, a, b, cin, sub, out_ready,
        output in_ready, out_valid, s, cout, ovf
    );
endinterface

// File: rtl/add_sub_pipe.sv
// add_sub_pipe: pipelined WIDTH-bit adder/subtractor, one carry chunk per stage, valid/ready stream
module add_sub_pipe #(
    parameter int WIDTH  = 16,
    parameter int STAGES = 4
) (
    input logic      clk,
    input logic      rst,
    add_sub_if.slave bus
);
    localparam int C = WIDTH / (STAGES < 1 ? 1 : STAGES);
    if (WIDTH < 1 || STAGES < 1 || WIDTH % STAGES != 0) begin : g_bad_cfg
        $error("add_sub_pipe: WIDTH must be a positive multiple of STAGES");
    end
    logic adv;
    assign adv          = !bus.out_valid | bus.out_ready;
    assign bus.in_ready = adv & !rst;
    // Stage k consumes the low chunk of the remaining operands and appends it above the partial sum
    for (genvar k = 0; k < STAGES; k++) begin : g_st
        localparam int R = WIDTH - k * C;
        localparam int P = (k + 1) * C;
        logic [R-1:0] ai, bi;
        logic [P-1:0] sn, sr;
        logic [C:0]   sum;
        logic         ci, vi, ami, bmi, v, cr;
        if (k == 0) begin : g_src
            assign ai  = bus.a;
            assign bi  = bus.sub ? ~bus.b : bus.b;
            assign ci  = bus.sub | bus.cin;
            assign vi  = bus.in_valid & bus.in_ready;
            assign ami = bus.a[WIDTH-1];
            assign bmi = bi[R-1];
            assign sn  = sum[C-1:0];
        end else begin : g_src
            assign ai  = g_st[k-1].g_fwd.ar;
            assign bi  = g_st[k-1].g_fwd.br;
            assign ci  = g_st[k-1].cr;
            assign vi  = g_st[k-1].v;
            assign ami = g_st[k-1].g_fwd.am;
            assign bmi = g_st[k-1].g_fwd.bm;
            assign sn  = {sum[C-1:0], g_st[k-1].sr};
        end
        assign sum = {1'b0, ai[C-1:0]} + {1'b0, bi[C-1:0]} + {{C{1'b0}}, ci};
        always_ff @(posedge clk) begin
            if (rst) begin
                v  <= 1'b0;
                sr <= '0;
                cr <= 1'b0;
            end else if (adv) begin
                v <= vi;
                if (vi) begin
                    sr <= sn;
                    cr <= sum[C];
                end
            end
        end
        if (k < STAGES - 1) begin : g_fwd
            logic [R-C-1:0] ar, br;
            logic           am, bm;
            always_ff @(posedge clk) begin
                if (rst) begin
                    ar <= '0;
                    br <= '0;
                    am <= 1'b0;
                    bm <= 1'b0;
                end else if (adv & vi) begin
                    ar <= ai[R-1:C];
                    br <= bi[R-1:C];
                    am <= ami;
                    bm <= bmi;
                end
            end
        end else begin : g_out
            logic ovf_r;
            always_ff @(posedge clk) begin
                if (rst) ovf_r <= 1'b0;
                else if (adv & vi) ovf_r <= (ami == bmi) & (sum[C-1] != ami);
            end
            assign bus.out_valid = v;
            assign bus.s         = sr;
            assign bus.cout      = cr;
            assign bus.ovf       = ovf_r;
        end
    end
endmodule

// File: tb/tb_add_sub_pipe.sv
// tb_add_sub_pipe: scoreboard bench for add_sub_pipe (16/4 plus 4-bit 1- and 2-stage variants)
module tb_add_sub_pipe;
    typedef struct packed {
        logic        ovf;
        logic        cout;
        logic [15:0] s;
    } res_t;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int   checks = 0, errors = 0, cyc = 0, mode = 0, last_pop = 0;
    res_t q16[$], q1[$], q2[$];
    add_sub_if #(.WIDTH(16)) b16 ();
    add_sub_if #(.WIDTH(4))  b1 ();
    add_sub_if #(.WIDTH(4))  b2 ();
    add_sub_pipe #(.WIDTH(16), .STAGES(4)) dut16 (.clk(clk), .rst(rst), .bus(b16));
    add_sub_pipe #(.WIDTH(4),  .STAGES(1)) dut1  (.clk(clk), .rst(rst), .bus(b1));
    add_sub_pipe #(.WIDTH(4),  .STAGES(2)) dut2  (.clk(clk), .rst(rst), .bus(b2));
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(string name, logic [31:0] act, logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic fail(string name);
        checks++;
        errors++;
        $display("FAIL %s: got timeout/unexpected expected none", name);
    endtask

    // Reference: plain integer arithmetic on unsigned and signed interpretations
    function automatic res_t model(int w, logic [15:0] a, logic [15:0] b, logic cin, logic sub);
        longint m, ua, ub, sa, sb, r, sr;
        res_t   x;
        m  = longint'(1) << w;
        ua = longint'(a);
        ub = longint'(b);
        sa = (ua >= m / 2) ? ua - m : ua;
        sb = (ub >= m / 2) ? ub - m : ub;
        r  = sub ? ua - ub : ua + ub + longint'(cin);
        sr = sub ? sa - sb : sa + sb + longint'(cin);
        x.s    = 16'(((r % m) + m) % m);
        x.cout = sub ? (ua >= ub) : (r >= m);
        x.ovf  = (sr >= m / 2) || (sr < -(m / 2));
        return x;
    endfunction

    // out_ready driver: 0 = always ready, 1 = never ready, 2 = random 50%
    initial forever begin
        @(posedge clk);
        #2;
        b16.out_ready = (mode == 2) ? 1'($urandom_range(0, 1)) : (mode == 0);
    end

    logic stall_p = 1'b0;
    res_t held;
    always @(negedge clk) begin
        res_t got, g1, g2, e;
        got = {b16.ovf, b16.cout, b16.s};
        g1  = {b1.ovf, b1.cout, 12'h000, b1.s};
        g2  = {b2.ovf, b2.cout, 12'h000, b2.s};
        check("in_ready16", b16.in_ready, (!b16.out_valid | b16.out_ready) & !rst);
        if (stall_p) begin
            check("stall_valid", b16.out_valid, 1);
            check("stall_hold", got, held);
        end
        stall_p = b16.out_valid & !b16.out_ready & !rst;
        held    = got;
        if (b16.out_valid & b16.out_ready & !rst) begin
            if (q16.size() == 0) fail("spurious16");
            else begin
                e = q16.pop_front();
                check("result16", got, e);
                last_pop = cyc;
            end
        end
        if (b1.out_valid & !rst) begin
            if (q1.size() == 0) fail("spurious4s1");
            else begin
                e = q1.pop_front();
                check("result4s1", g1, e);
            end
        end
        if (b2.out_valid & !rst) begin
            if (q2.size() == 0) fail("spurious4s2");
            else begin
                e = q2.pop_front();
                check("result4s2", g2, e);
            end
        end
    end

    task automatic send(logic [15:0] a, logic [15:0] b, logic cin, logic sub, res_t e);
        int n = 0;
        b16.in_valid = 1'b1;
        b16.a = a;
        b16.b = b;
        b16.cin = cin;
        b16.sub = sub;
        @(negedge clk);
        while (!b16.in_ready && n < 200) begin
            n++;
            @(negedge clk);
        end
        if (n >= 200) fail("accept_timeout");
        else q16.push_back(e);
        @(posedge clk);
        #1;
        b16.in_valid = 1'b0;
    endtask

    task automatic send_rand();
        logic [15:0] a, b;
        logic        cin, sub;
        a   = 16'($urandom);
        b   = 16'($urandom);
        cin = 1'($urandom_range(0, 1));
        sub = 1'($urandom_range(0, 1));
        send(a, b, cin, sub, model(16, a, b, cin, sub));
    endtask

    task automatic drain();
        int n = 0;
        while ((q16.size() != 0 || q1.size() != 0 || q2.size() != 0) && n < 400) begin
            n++;
            @(negedge clk);
        end
        if (n >= 400) fail("drain_timeout");
        @(posedge clk);
        #1;
    endtask

    initial begin
        int c0, n;
        b16.in_valid = 1'b0; b16.a = '0; b16.b = '0; b16.cin = 1'b0; b16.sub = 1'b0;
        b16.out_ready = 1'b1;
        b1.in_valid = 1'b0; b1.a = '0; b1.b = '0; b1.cin = 1'b0; b1.sub = 1'b0; b1.out_ready = 1'b1;
        b2.in_valid = 1'b0; b2.a = '0; b2.b = '0; b2.cin = 1'b0; b2.sub = 1'b0; b2.out_ready = 1'b1;
        @(negedge clk);
        check("rst_in_ready", b16.in_ready, 0);
        check("rst_out_valid", b16.out_valid, 0);
        check("rst_s", b16.s, 0);
        check("rst_cout_ovf", {b16.cout, b16.ovf}, 0);
        @(posedge clk);
        #1 rst = 1'b0;
        // Single beat and exact latency
        send(16'h1234, 16'h0FF0, 1'b1, 1'b0, {1'b0, 1'b0, 16'h2225});
        for (int i = 1; i <= 4; i++) begin
            @(negedge clk);
            check("latency_valid", b16.out_valid, (i == 4));
        end
        @(posedge clk);
        #1;
        // Wrap-around and signed overflow corners
        send(16'h7FFF, 16'h0001, 1'b0, 1'b0, {1'b1, 1'b0, 16'h8000});
        send(16'h0000, 16'h0001, 1'b0, 1'b1, {1'b0, 1'b0, 16'hFFFF});
        send(16'h8000, 16'h0001, 1'b1, 1'b1, {1'b1, 1'b1, 16'h7FFF});
        send(16'hFFFF, 16'h0001, 1'b0, 1'b0, {1'b0, 1'b1, 16'h0000});
        drain();
        // Back-to-back stream, full throughput
        c0 = cyc;
        for (int i = 0; i < 100; i++) send_rand();
        drain();
        check("throughput", last_pop - c0, 103);
        // Random backpressure
        mode = 2;
        for (int i = 0; i < 150; i++) send_rand();
        mode = 0;
        drain();
        // Reset with results in flight and a stalled output
        mode = 1;
        for (int i = 0; i < 3; i++) send_rand();
        n = 0;
        while (!b16.out_valid && n < 20) begin
            n++;
            @(negedge clk);
        end
        if (n >= 20) fail("inflight_timeout");
        @(posedge clk);
        #1 rst = 1'b1;
        q16.delete();
        @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        check("midrst_valid", b16.out_valid, 0);
        check("midrst_s", b16.s, 0);
        mode = 0;
        repeat (20) @(negedge clk);
        @(posedge clk);
        #1;
        // Exhaustive 4-bit, one- and two-stage variants
        for (int sub = 0; sub < 2; sub++)
            for (int cin = 0; cin < 2; cin++)
                for (int a = 0; a < 16; a++)
                    for (int b = 0; b < 16; b++) begin
                        b1.in_valid = 1'b1; b1.a = 4'(a); b1.b = 4'(b); b1.cin = 1'(cin); b1.sub = 1'(sub);
                        b2.in_valid = 1'b1; b2.a = 4'(a); b2.b = 4'(b); b2.cin = 1'(cin); b2.sub = 1'(sub);
                        @(negedge clk);
                        check("in_ready4", {b1.in_ready, b2.in_ready}, 2'b11);
                        q1.push_back(model(4, 16'(a), 16'(b), 1'(cin), 1'(sub)));
                        q2.push_back(model(4, 16'(a), 16'(b), 1'(cin), 1'(sub)));
                        @(posedge clk);
                        #1;
                    end
        b1.in_valid = 1'b0;
        b2.in_valid = 1'b0;
        drain();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: got no finish expected finish");
        $fatal(1, "watchdog expired");
    end
endmodule
